hp48_bus_ctrl: RTL and testbench

HP48_BUS_CTRL -- requirements
Module: hp48_bus_ctrl

---
 rtl/hp48_bus_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_hp48_bus_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp48_bus_ctrl.sv
// hp48_bus_ctrl: nibble-serial bus controller with PC/DP pointers and a bank of
// configurable memory controllers (mask/base decode, lowest index wins).
// Ports:
//   strobe       clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   cmd_valid    command present, sampled only while busy=0
//   command      4-bit opcode (0 NOP .. 9 C_ID, 10-15 illegal)
//   nibble_in    write data or shifted address/config nibble, LSB nibble first
//   busy         multi-nibble sequence in progress
//   nibble_out   registered read data or C_ID nibble
//   bus_error    one-cycle error pulse
//   addr_out     address of the current access, holds last value otherwise
//   dev_sel      one-hot device select during an access cycle
//   rom_sel      ROM select when no device hits during an access cycle
//   dev_we       write enable for the selected device
//   dev_rdata    device read nibbles, device i on [4i+3:4i]
//   rom_rdata    ROM read nibble
module hp48_bus_ctrl #(
    parameter int                    NUM_DEV = 4,
    parameter logic [20*NUM_DEV-1:0] DEV_IDS = '0
) (
    input  logic                   strobe,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [3:0]             command,
    input  logic [3:0]             nibble_in,
    output logic                   busy,
    output logic [3:0]             nibble_out,
    output logic                   bus_error,
    output logic [19:0]            addr_out,
    output logic [NUM_DEV-1:0]     dev_sel,
    output logic                   rom_sel,
    output logic                   dev_we,
    input  logic [4*NUM_DEV-1:0]   dev_rdata,
    input  logic [3:0]             rom_rdata
);

    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_PC_READ   = 4'd1;
    localparam logic [3:0] CMD_DP_READ   = 4'd2;
    localparam logic [3:0] CMD_DP_WRITE  = 4'd3;
    localparam logic [3:0] CMD_LOAD_PC   = 4'd4;
    localparam logic [3:0] CMD_LOAD_DP   = 4'd5;
    localparam logic [3:0] CMD_CONFIGURE = 4'd6;
    localparam logic [3:0] CMD_UNCONFIG  = 4'd7;
    localparam logic [3:0] CMD_RESET_CFG = 4'd8;
    localparam logic [3:0] CMD_C_ID      = 4'd9;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
    typedef enum logic [1:0] {DEV_UNCONF = 2'd0, DEV_SIZED = 2'd1, DEV_CONF = 2'd2} dev_state_t;

    state_t      state_reg;
    logic [3:0]  op_reg;
    logic [2:0]  cnt_reg;
    logic [19:0] shift_reg;
    logic [19:0] pc_reg;
    logic [19:0] dp_reg;
    logic [19:0] addr_reg;
    logic [3:0]  nibble_reg;
    logic        busy_reg;
    logic        err_reg;

    logic [19:0] mask_reg      [NUM_DEV];
    logic [19:0] base_reg      [NUM_DEV];
    dev_state_t  dev_state_reg [NUM_DEV];

    logic               accept;
    logic               is_access;
    logic               is_write;
    logic [19:0]        acc_addr;
    logic [19:0]        shift_full;
    logic [NUM_DEV-1:0] acc_hit;
    logic [NUM_DEV-1:0] acc_win;
    logic [NUM_DEV-1:0] unc_hit;
    logic [NUM_DEV-1:0] unc_win;
    logic [NUM_DEV-1:0] not_conf;
    logic [NUM_DEV-1:0] cfg_win;
    logic               acc_any;
    logic [3:0]         rdata_sel;
    logic [19:0]        cid_word;
    logic [2:0]         cid_idx;
    logic [3:0]         cid_nib;

    // Commands are only taken while idle and out of reset, so the access
    // strobes stay low during reset and during a shift sequence.
    assign accept     = reset && (state_reg == ST_IDLE) && cmd_valid;
    assign is_write   = (command == CMD_DP_WRITE);
    assign is_access  = accept && ((command == CMD_PC_READ) || (command == CMD_DP_READ) || is_write);
    assign acc_addr   = (command == CMD_PC_READ) ? pc_reg : dp_reg;
    // The fifth nibble is still on nibble_in when the sequence commits.
    assign shift_full = {nibble_in, shift_reg[19:4]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign acc_hit[gi]  = (dev_state_reg[gi] == DEV_CONF) &&
                                  ((acc_addr & mask_reg[gi]) == base_reg[gi]);
            assign unc_hit[gi]  = (dev_state_reg[gi] == DEV_CONF) &&
                                  ((shift_full & mask_reg[gi]) == base_reg[gi]);
            assign not_conf[gi] = (dev_state_reg[gi] != DEV_CONF);
        end
    endgenerate

    // Isolate the lowest set bit: lowest index has priority.
    assign acc_win = acc_hit  & (~acc_hit  + NUM_DEV'(1));
    assign unc_win = unc_hit  & (~unc_hit  + NUM_DEV'(1));
    assign cfg_win = not_conf & (~not_conf + NUM_DEV'(1));
    assign acc_any = |acc_hit;

    always_comb begin
        rdata_sel = rom_rdata;
        cid_word  = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (acc_win[i]) rdata_sel = dev_rdata[4*i +: 4];
            if (cfg_win[i]) cid_word  = DEV_IDS[20*i +: 20];
        end
    end

    // nibble_out leads the shift counter by one: nibble k is shown during shift cycle k.
    assign cid_idx = (state_reg == ST_SHIFT) ? (cnt_reg + 3'd1) : 3'd0;

    always_comb begin
        case (cid_idx)
            3'd0:    cid_nib = cid_word[3:0];
            3'd1:    cid_nib = cid_word[7:4];
            3'd2:    cid_nib = cid_word[11:8];
            3'd3:    cid_nib = cid_word[15:12];
            default: cid_nib = cid_word[19:16];
        endcase
    end

    assign busy       = busy_reg;
    assign nibble_out = nibble_reg;
    assign bus_error  = err_reg;
    assign addr_out   = is_access ? acc_addr : addr_reg;
    assign dev_sel    = is_access ? acc_win : '0;
    assign rom_sel    = is_access && !acc_any;
    assign dev_we     = accept && is_write && acc_any;

    always_ff @(posedge strobe) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= CMD_NOP;
            cnt_reg    <= 3'd0;
            shift_reg  <= '0;
            pc_reg     <= '0;
            dp_reg     <= '0;
            addr_reg   <= '0;
            nibble_reg <= '0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < NUM_DEV; i++) begin
                mask_reg[i]      <= '0;
                base_reg[i]      <= '0;
                dev_state_reg[i] <= DEV_UNCONF;
            end
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (command)
                            CMD_NOP: ;
                            CMD_PC_READ: begin
                                nibble_reg <= rdata_sel;
                                addr_reg   <= acc_addr;
                                pc_reg     <= pc_reg + 20'd1;
                            end
                            CMD_DP_READ: begin
                                nibble_reg <= rdata_sel;
                                addr_reg   <= acc_addr;
                                dp_reg     <= dp_reg + 20'd1;
                            end
                            CMD_DP_WRITE: begin
                                addr_reg <= acc_addr;
                                dp_reg   <= dp_reg + 20'd1;
                                if (!acc_any) err_reg <= 1'b1;
                            end
                            CMD_LOAD_PC, CMD_LOAD_DP, CMD_CONFIGURE, CMD_UNCONFIG, CMD_C_ID: begin
                                state_reg <= ST_SHIFT;
                                busy_reg  <= 1'b1;
                                cnt_reg   <= 3'd0;
                                op_reg    <= command;
                                if (command == CMD_C_ID) nibble_reg <= cid_nib;
                            end
                            CMD_RESET_CFG: begin
                                for (int i = 0; i < NUM_DEV; i++) dev_state_reg[i] <= DEV_UNCONF;
                            end
                            default: err_reg <= 1'b1;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= shift_full;
                    cnt_reg   <= cnt_reg + 3'd1;
                    if (op_reg == CMD_C_ID && cnt_reg != 3'd4) nibble_reg <= cid_nib;
                    if (cnt_reg == 3'd4) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        case (op_reg)
                            CMD_LOAD_PC: pc_reg <= shift_full;
                            CMD_LOAD_DP: dp_reg <= shift_full;
                            CMD_CONFIGURE: begin
                                for (int i = 0; i < NUM_DEV; i++) begin
                                    if (cfg_win[i]) begin
                                        if (dev_state_reg[i] == DEV_UNCONF) begin
                                            mask_reg[i]      <= shift_full;
                                            dev_state_reg[i] <= DEV_SIZED;
                                        end else begin
                                            base_reg[i]      <= shift_full & mask_reg[i];
                                            dev_state_reg[i] <= DEV_CONF;
                                        end
                                    end
                                end
                            end
                            CMD_UNCONFIG: begin
                                for (int i = 0; i < NUM_DEV; i++) begin
                                    if (unc_win[i]) dev_state_reg[i] <= DEV_UNCONF;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hp48_bus_ctrl.sv
// Self-checking bench for hp48_bus_ctrl: directed scenarios followed by a
// randomized command stream, each checked against a behavioural model of the
// pointers and the device configuration table.
module tb_hp48_bus_ctrl;

    localparam int          ND  = 4;
    localparam logic [79:0] IDS = {20'hFEDCB, 20'h6789A, 20'h12345, 20'h0ABCD};

    logic        strobe = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  command = 4'd0;
    logic [3:0]  nibble_in = 4'd0;
    logic        busy;
    logic [3:0]  nibble_out;
    logic        bus_error;
    logic [19:0] addr_out;
    logic [ND-1:0] dev_sel;
    logic        rom_sel;
    logic        dev_we;
    logic [4*ND-1:0] dev_rdata = '0;
    logic [3:0]  rom_rdata = 4'd0;

    hp48_bus_ctrl #(.NUM_DEV(ND), .DEV_IDS(IDS)) dut (
        .strobe(strobe), .reset(reset), .cmd_valid(cmd_valid), .command(command),
        .nibble_in(nibble_in), .busy(busy), .nibble_out(nibble_out), .bus_error(bus_error),
        .addr_out(addr_out), .dev_sel(dev_sel), .rom_sel(rom_sel), .dev_we(dev_we),
        .dev_rdata(dev_rdata), .rom_rdata(rom_rdata)
    );

    always #5 strobe = ~strobe;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [19:0] m_pc, m_dp, m_last;
    logic [19:0] m_mask [ND];
    logic [19:0] m_base [ND];
    int          m_st   [ND];   // 0 unconfigured, 1 sized, 2 configured
    logic [ND-1:0] obs_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge strobe);
        #1;
    endtask

    task automatic model_reset();
        m_pc = '0; m_dp = '0; m_last = '0;
        for (int i = 0; i < ND; i++) begin
            m_mask[i] = '0; m_base[i] = '0; m_st[i] = 0;
        end
    endtask

    function automatic int win_of(input logic [19:0] a);
        for (int i = 0; i < ND; i++)
            if (m_st[i] == 2 && (a & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    function automatic int cfg_target();
        for (int i = 0; i < ND; i++)
            if (m_st[i] != 2) return i;
        return -1;
    endfunction

    function automatic logic [ND-1:0] sel_of(input int w);
        logic [ND-1:0] s;
        s = '0;
        if (w >= 0) s[w] = 1'b1;
        return s;
    endfunction

    function automatic logic [19:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return {4'h8, 16'($urandom)};
            1: return 20'hFFFFF;
            2: return {8'h80, 12'($urandom)};
            default: return 20'($urandom);
        endcase
    endfunction

    task automatic do_read(input bit use_pc);
        int w; logic [19:0] a; logic [3:0] expd;
        a = use_pc ? m_pc : m_dp;
        w = win_of(a);
        dev_rdata = 16'($urandom);
        rom_rdata = 4'($urandom);
        command = use_pc ? 4'd1 : 4'd2;
        cmd_valid = 1'b1;
        #1;
        obs_sel = dev_sel;
        check("rd_addr", addr_out, a);
        check("rd_sel", dev_sel, sel_of(w));
        check("rd_rom", rom_sel, w < 0);
        check("rd_we", dev_we, 0);
        expd = (w >= 0) ? dev_rdata[4*w +: 4] : rom_rdata;
        tick();
        cmd_valid = 1'b0;
        check("rd_data", nibble_out, expd);
        check("rd_err", bus_error, 0);
        if (use_pc) m_pc = a + 20'd1; else m_dp = a + 20'd1;
        m_last = a;
    endtask

    task automatic do_write();
        int w; logic [19:0] a;
        a = m_dp;
        w = win_of(a);
        nibble_in = 4'($urandom);
        command = 4'd3;
        cmd_valid = 1'b1;
        #1;
        obs_sel = dev_sel;
        check("wr_addr", addr_out, a);
        check("wr_sel", dev_sel, sel_of(w));
        check("wr_rom", rom_sel, w < 0);
        check("wr_we", dev_we, w >= 0);
        tick();
        cmd_valid = 1'b0;
        check("wr_err", bus_error, w < 0);
        m_dp = a + 20'd1;
        m_last = a;
        tick();
        check("wr_err_end", bus_error, 0);
        check("idle_we", dev_we, 0);
        check("idle_sel", {dev_sel, rom_sel}, 0);
        check("idle_addr", addr_out, m_last);
    endtask

    task automatic do_single(input logic [3:0] cmd);
        command = cmd;
        cmd_valid = 1'b1;
        #1;
        check("one_sel", {dev_sel, rom_sel, dev_we}, 0);
        check("one_addr", addr_out, m_last);
        tick();
        cmd_valid = 1'b0;
        check("one_busy", busy, 0);
        check("one_err", bus_error, cmd >= 4'd10);
        if (cmd == 4'd8) for (int i = 0; i < ND; i++) m_st[i] = 0;
        tick();
        check("one_err_end", bus_error, 0);
    endtask

    task automatic do_shift(input logic [3:0] cmd, input logic [19:0] v);
        int t; int w; logic [19:0] cid;
        t = cfg_target();
        cid = (t >= 0) ? IDS[20*t +: 20] : 20'h0;
        command = cmd;
        cmd_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("sh_busy", busy, 1);
            check("sh_addr", addr_out, m_last);
            if (cmd == 4'd9) check("cid_nib", nibble_out, cid[4*k +: 4]);
            nibble_in = v[4*k +: 4];
            cmd_valid = 1'($urandom);
            command = 4'($urandom);
            tick();
        end
        cmd_valid = 1'b0;
        check("sh_done", busy, 0);
        case (cmd)
            4'd4: m_pc = v;
            4'd5: m_dp = v;
            4'd6: if (t >= 0) begin
                if (m_st[t] == 0) begin m_mask[t] = v; m_st[t] = 1; end
                else begin m_base[t] = v & m_mask[t]; m_st[t] = 2; end
            end
            4'd7: begin
                w = win_of(v);
                if (w >= 0) m_st[w] = 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [19:0] masks [4];
        logic [19:0] v;
        int r, t;
        masks[0] = 20'hF0000; masks[1] = 20'hFF000; masks[2] = 20'hFFF00; masks[3] = 20'h00000;

        // Reset state
        model_reset();
        reset = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_nib", nibble_out, 0);
        check("rst_err", bus_error, 0);
        check("rst_addr", addr_out, 0);
        check("rst_sel", {dev_sel, rom_sel, dev_we}, 0);
        reset = 1'b1;
        tick();

        // LOAD_DP 5,4,3,2,1 then reads
        do_shift(4'd5, 20'h12345);
        do_read(1'b0);
        check("dp_load_addr", m_last, 20'h12345);
        do_read(1'b0);

        // C_ID with everything unconfigured targets device 0
        do_shift(4'd9, 20'h0);

        // Device 0 covering 0x80000 page, read via PC
        do_shift(4'd6, 20'hFF000);
        do_shift(4'd6, 20'h80000);
        do_shift(4'd4, 20'h80010);
        do_read(1'b1);
        check("dev0_sel", obs_sel, 4'b0001);

        // Device 1 overlaps device 0; priority then unconfigure
        do_shift(4'd6, 20'hF0000);
        do_shift(4'd6, 20'h80000);
        do_shift(4'd5, 20'h80000);
        do_read(1'b0);
        check("prio_sel", obs_sel, 4'b0001);
        do_shift(4'd7, 20'h80000);
        do_shift(4'd5, 20'h80000);
        do_read(1'b0);
        check("unconf_sel", obs_sel, 4'b0010);

        // ROM write at the top of the address space, DP wraps
        do_shift(4'd5, 20'hFFFFF);
        do_write();
        do_read(1'b0);
        check("wrap_addr", m_last, 20'h00000);

        // Illegal command and NOP leave state alone
        do_single(4'd12);
        do_single(4'd0);
        do_read(1'b0);

        // Write to a hit device
        do_shift(4'd5, 20'h80005);
        do_write();
        check("wr_dev_sel", obs_sel, 4'b0010);

        // Fill every device, then C_ID and CONFIGURE have no target
        do_shift(4'd6, 20'hFF000);
        do_shift(4'd6, 20'h80000);
        do_shift(4'd6, 20'hFFF00);
        do_shift(4'd6, 20'h12345);
        do_shift(4'd6, 20'h00000);
        do_shift(4'd6, 20'h77777);
        do_shift(4'd9, 20'h0);
        do_shift(4'd6, 20'h11111);
        do_shift(4'd5, 20'h55555);
        do_read(1'b0);
        check("dev3_sel", obs_sel, 4'b1000);
        do_single(4'd8);
        do_read(1'b0);

        // Reset during the third nibble of LOAD_PC
        command = 4'd4; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; nibble_in = 4'd7;
        tick();
        nibble_in = 4'd8;
        tick();
        nibble_in = 4'd9; reset = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_nib", nibble_out, 0);
        reset = 1'b1;
        model_reset();
        do_read(1'b1);
        check("midrst_pc", m_last, 20'h0);

        // Randomized command stream
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1: do_read(1'b1);
                2, 3: do_read(1'b0);
                4: do_write();
                5: do_shift(4'd4, rand_addr());
                6: do_shift(4'd5, rand_addr());
                7: begin
                    t = cfg_target();
                    v = (t >= 0 && m_st[t] == 0) ? masks[$urandom_range(0, 3)] : rand_addr();
                    do_shift(4'd6, v);
                end
                8: do_shift(4'd7, rand_addr());
                9: do_shift(4'd9, rand_addr());
                10: do_single(($urandom_range(0, 3) == 0) ? 4'd8 : 4'd0);
                default: do_single(4'($urandom_range(10, 15)));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
